// File: rtl/bist_engine.sv
// BIST engine: a Fibonacci LFSR drives the CUT and a MISR compacts its responses.
// A control FSM runs N patterns, waits out CUT latency and compares against a golden signature.
module bist_engine #(
  parameter int              PAT_W    = 8,
  parameter logic [PAT_W-1:0] PAT_POLY = 8'hB8,
  parameter logic [PAT_W-1:0] PAT_SEED = 8'hFF,
  parameter int              SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'hB400,
  parameter logic [SIG_W-1:0] SIG_SEED = 16'h0001,
  parameter int              RESP_W   = 8,
  parameter int              CNT_W    = 16,
  parameter int              CUT_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [SIG_W-1:0]  golden,
  output logic [PAT_W-1:0]  pattern,
  output logic              pattern_valid,
  input  logic [RESP_W-1:0] response,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  if (PAT_SEED == '0) begin : g_chk_seed
    $error("bist_engine: PAT_SEED must be nonzero");
  end
  if (RESP_W > SIG_W) begin : g_chk_resp
    $error("bist_engine: RESP_W must not exceed SIG_W");
  end
  if (CUT_LAT < 0 || CUT_LAT > 7) begin : g_chk_lat
    $error("bist_engine: CUT_LAT must be in 0..7");
  end
  if (PAT_W < 2 || SIG_W < 2) begin : g_chk_w
    $error("bist_engine: PAT_W and SIG_W must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [2:0] LAT_M1 = (CUT_LAT > 0) ? 3'(CUT_LAT - 1) : 3'd0;

  state_t            state_r;
  logic [PAT_W-1:0]  q_r;
  logic [SIG_W-1:0]  s_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        drain_r;
  logic              pattern_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic              mvalid_s;

  function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] q);
    return {q[PAT_W-2:0], ^(q & PAT_POLY)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [RESP_W-1:0] r);
    logic [SIG_W-1:0] ext;
    ext = '0;
    ext[RESP_W-1:0] = r;
    return {s[SIG_W-2:0], ^(s & SIG_POLY)} ^ ext;
  endfunction

  // The MISR samples a response only when the valid bit of its pattern emerges from the latency pipe.
  if (CUT_LAT == 0) begin : g_nolat
    assign mvalid_s = pattern_valid_r;
  end else begin : g_lat
    logic [CUT_LAT-1:0] pipe_r;
    logic [CUT_LAT-1:0] pipe_s;

    // Next value of the valid delay pipe
    always_comb begin
      pipe_s    = pipe_r << 1;
      pipe_s[0] = pattern_valid_r;
    end

    // Valid delay pipe, flushed on abort
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_r <= '0;
      end else if (abort) begin
        pipe_r <= '0;
      end else begin
        pipe_r <= pipe_s;
      end
    end

    assign mvalid_s = pipe_r[CUT_LAT-1];
  end

  // Control FSM with LFSR, MISR, counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      q_r             <= PAT_SEED;
      s_r             <= SIG_SEED;
      cnt_r           <= '0;
      drain_r         <= 3'd0;
      pattern_valid_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      pass_r          <= 1'b0;
    end else if (abort && state_r != IDLE) begin
      state_r         <= IDLE;
      q_r             <= PAT_SEED;
      s_r             <= SIG_SEED;
      pattern_valid_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      pass_r          <= 1'b0;
    end else begin
      if (mvalid_s) begin
        s_r <= misr_next(s_r, response);
      end
      case (state_r)
        IDLE, DONE: begin
          if (start && !abort) begin
            state_r <= SEED;
            q_r     <= PAT_SEED;
            s_r     <= SIG_SEED;
            cnt_r   <= num_patterns;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
          end
        end
        SEED: begin
          if (cnt_r != '0) begin
            state_r         <= RUN;
            pattern_valid_r <= 1'b1;
          end else if (CUT_LAT > 0) begin
            state_r <= DRAIN;
            drain_r <= LAT_M1;
          end else begin
            state_r <= COMPARE;
          end
        end
        RUN: begin
          q_r   <= lfsr_next(q_r);
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            pattern_valid_r <= 1'b0;
            if (CUT_LAT > 0) begin
              state_r <= DRAIN;
              drain_r <= LAT_M1;
            end else begin
              state_r <= COMPARE;
            end
          end
        end
        DRAIN: begin
          if (drain_r == 3'd0) begin
            state_r <= COMPARE;
          end else begin
            drain_r <= drain_r - 3'd1;
          end
        end
        COMPARE: begin
          pass_r  <= (s_r == golden);
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign pattern       = q_r;
  assign pattern_valid = pattern_valid_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign signature     = s_r;

endmodule
